// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-access sequencer.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WR_DATA,
    ST_WR_BUS,
    ST_RD_BUS,
    ST_RD_PRESENT,
    ST_DRAIN
  } state_e;

  localparam int         CMD_RD_BIT  = 7;
  localparam logic [7:0] FILLER_BYTE = 8'h00;

  // Counter width able to hold 0 .. timeout-1.
  function automatic int tmo_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/axis_spi_reg_ctrl.sv
// Frame sequencer [cmd][addr][data...] between an AXI-stream SPI slave and a register bus.
// Build option SPI_REG_CTRL_AUTOINC_EN: address increments after each data byte (burst).
module axis_spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic                  reg_wr_en,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_ack,
  output logic                  busy,
  output logic                  err
);

  localparam int TW = tmo_width(TIMEOUT);

  state_e                  state_q;
  logic                    rd_cmd_q;
  logic                    last_q;
  logic [TW-1:0]           tmo_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [DATA_WIDTH-1:0]   tdata_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic                    tready_q;
  logic                    tvalid_q;
  logic                    wr_en_q;
  logic                    rd_en_q;
  logic                    err_q;
  logic                    rx_fire;
  logic                    bus_tmo;

  assign rx_fire = input_axis_tvalid && tready_q;
  assign bus_tmo = (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    addr_d = addr_q;
`ifdef SPI_REG_CTRL_AUTOINC_EN
    addr_d = addr_q + ADDR_WIDTH'(1);
`else
    addr_d = addr_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rd_cmd_q  <= 1'b0;
      last_q    <= 1'b0;
      tmo_q     <= '0;
      addr_q    <= '0;
      tdata_q   <= '0;
      wr_data_q <= '0;
      tready_q  <= 1'b0;
      tvalid_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tready_q <= 1'b1;
          if (rx_fire) begin
            err_q    <= 1'b0;
            rd_cmd_q <= input_axis_tdata[CMD_RD_BIT];
            if (!input_axis_tlast) state_q <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (rx_fire) begin
            if (input_axis_tlast) begin
              state_q <= ST_IDLE;
            end else begin
              addr_q <= input_axis_tdata[ADDR_WIDTH-1:0];
              tmo_q  <= '0;
              if (rd_cmd_q) begin
                rd_en_q <= 1'b1;
                state_q <= ST_RD_BUS;
              end else begin
                state_q <= ST_WR_DATA;
              end
            end
          end
        end
        ST_WR_DATA: begin
          if (rx_fire) begin
            wr_data_q <= input_axis_tdata;
            last_q    <= input_axis_tlast;
            wr_en_q   <= 1'b1;
            tmo_q     <= '0;
            tready_q  <= 1'b0;
            state_q   <= ST_WR_BUS;
          end
        end
        ST_WR_BUS: begin
          // A timed-out write is simply abandoned; the frame keeps going.
          if (reg_ack || bus_tmo) begin
            if (!reg_ack) err_q <= 1'b1;
            addr_q   <= addr_d;
            tready_q <= 1'b1;
            state_q  <= last_q ? ST_IDLE : ST_WR_DATA;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        ST_RD_BUS: begin
          // End of frame wins over a coincident ack: the data has no slot left.
          if (rx_fire && input_axis_tlast) begin
            state_q <= ST_IDLE;
          end else if (reg_ack || bus_tmo) begin
            tdata_q  <= reg_ack ? reg_rd_data : DATA_WIDTH'(FILLER_BYTE);
            tvalid_q <= 1'b1;
            if (!reg_ack) err_q <= 1'b1;
            state_q  <= ST_RD_PRESENT;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        ST_RD_PRESENT: begin
          if (rx_fire && input_axis_tlast) begin
            tvalid_q <= 1'b0;
            state_q  <= ST_IDLE;
          end else if (output_axis_tready) begin
            tvalid_q <= 1'b0;
            addr_q   <= addr_d;
            rd_en_q  <= 1'b1;
            tmo_q    <= '0;
            state_q  <= ST_RD_BUS;
          end
        end
        ST_DRAIN: begin
          tvalid_q <= 1'b0;
          if (rx_fire && input_axis_tlast) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign input_axis_tready  = tready_q;
  assign output_axis_tdata  = tdata_q;
  assign output_axis_tvalid = tvalid_q;
  assign output_axis_tlast  = 1'b0;
  assign reg_addr           = addr_q;
  assign reg_wr_data        = wr_data_q;
  assign reg_wr_en          = wr_en_q;
  assign reg_rd_en          = rd_en_q;
  assign busy               = (state_q != ST_IDLE);
  assign err                = err_q;

endmodule

// File: tb/tb_axis_spi_reg_ctrl.sv
// Bench for axis_spi_reg_ctrl: SPI slave look-ahead model, register responder, frame-level reference.
module tb_axis_spi_reg_ctrl;

`ifdef SPI_REG_CTRL_AUTOINC_EN
  localparam int INC = 1;
`else
  localparam int INC = 0;
`endif
  localparam int GAP     = 80;
  localparam int ACK_LAT = 3;

  typedef struct packed {
    logic       rd;
    logic [7:0] addr;
    logic [7:0] data;
  } op_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] input_axis_tdata = 8'h00;
  logic       input_axis_tvalid = 1'b0;
  logic       input_axis_tready;
  logic       input_axis_tlast = 1'b0;
  logic [7:0] output_axis_tdata;
  logic       output_axis_tvalid;
  logic       output_axis_tready = 1'b0;
  logic       output_axis_tlast;
  logic [7:0] reg_addr;
  logic [7:0] reg_wr_data;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_rd_data = 8'h00;
  logic       reg_ack = 1'b0;
  logic       busy;
  logic       err;

  op_t        got_ops[$], exp_ops[$];
  logic [7:0] frame_q[$], tx_got[$], exp_tx[$];
  logic       exp_err;
  bit         ack_en = 1'b1;
  logic [7:0] salt = 8'h5A;
  logic [7:0] pend_addr = 8'h00;
  int         ack_cnt = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  axis_spi_reg_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .input_axis_tdata(input_axis_tdata), .input_axis_tvalid(input_axis_tvalid),
    .input_axis_tready(input_axis_tready), .input_axis_tlast(input_axis_tlast),
    .output_axis_tdata(output_axis_tdata), .output_axis_tvalid(output_axis_tvalid),
    .output_axis_tready(output_axis_tready), .output_axis_tlast(output_axis_tlast),
    .reg_addr(reg_addr), .reg_wr_data(reg_wr_data), .reg_wr_en(reg_wr_en),
    .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data), .reg_ack(reg_ack),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Register bus responder: logs each strobe, acks ACK_LAT cycles later when enabled.
  always @(negedge clk) begin
    if (!rst_n) begin
      ack_cnt = 0;
      reg_ack = 1'b0;
    end else begin
      reg_ack = 1'b0;
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) begin
          reg_ack     = 1'b1;
          reg_rd_data = pend_addr ^ salt;
        end
      end
      if (reg_wr_en || reg_rd_en) begin
        got_ops.push_back('{reg_rd_en, reg_addr, reg_rd_en ? 8'h00 : reg_wr_data});
        if (ack_en) begin
          ack_cnt   = ACK_LAT;
          pend_addr = reg_addr;
        end
      end
    end
  end

  // Frame-level reference: what the register bus and tx slots must show for frame_q.
  task automatic model();
    int n;
    logic [7:0] a;
    n = frame_q.size();
    exp_ops.delete();
    exp_tx.delete();
    exp_err = 1'b0;
    for (int s = 1; s < n; s++) exp_tx.push_back(8'h00);
    if (n < 3) return;
    a = frame_q[1];
    exp_err = !ack_en;
    if (frame_q[0][7]) begin
      for (int i = 0; i < n - 2; i++) exp_ops.push_back('{1'b1, 8'(a + i * INC), 8'h00});
      for (int s = 3; s < n; s++) exp_tx[s-1] = ack_en ? (8'(a + (s - 3) * INC) ^ salt) : 8'h00;
    end else begin
      for (int i = 2; i < n; i++) exp_ops.push_back('{1'b0, 8'(a + (i - 2) * INC), frame_q[i]});
    end
  endtask

  // SPI slave: the tx byte for slot k+1 is fetched before rx byte k completes.
  task automatic run_frame();
    int n;
    bit ok;
    logic [7:0] b;
    n = frame_q.size();
    got_ops.delete();
    tx_got.delete();
    for (int k = 0; k < n; k++) begin
      repeat (GAP) @(negedge clk);
      if (k + 1 < n) begin
        b = 8'h00;
        if (output_axis_tvalid) begin
          b = output_axis_tdata;
          output_axis_tready = 1'b1;
          @(negedge clk);
          output_axis_tready = 1'b0;
        end
        tx_got.push_back(b);
      end
      input_axis_tdata  = frame_q[k];
      input_axis_tlast  = (k == n - 1);
      input_axis_tvalid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
        if (input_axis_tready) begin
          @(posedge clk);
          ok = 1'b1;
        end
        @(negedge clk);
      end
      input_axis_tvalid = 1'b0;
      input_axis_tlast  = 1'b0;
      n_chk++;
      if (!ok) begin
        n_fail++;
        $display("FAIL rx_handshake: byte %0d not accepted, got tready=0 required 1", k);
      end
    end
    repeat (GAP) @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    n_chk++;
    if ({reg_wr_en, reg_rd_en, output_axis_tvalid, input_axis_tready, busy, err, output_axis_tlast} !== 7'b0
        || reg_addr !== 8'h00 || output_axis_tdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got wr=%b rd=%b tv=%b trdy=%b busy=%b err=%b addr=%h, required all 0",
               reg_wr_en, reg_rd_en, output_axis_tvalid, input_axis_tready, busy, err, reg_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (input_axis_tready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got tready=%b busy=%b, required 1 0", input_axis_tready, busy);
    end
  endtask

  task automatic test_write();
    ack_en = 1'b1;
    frame_q = '{8'h00, 8'h10, 8'hAA, 8'hBB};
    model();
    run_frame();
    n_chk++;
    if (got_ops.size() !== exp_ops.size()) begin n_fail++; $display("FAIL write_count: got %0d required %0d", got_ops.size(), exp_ops.size()); end
    foreach (exp_ops[i]) if (i < got_ops.size()) begin
      n_chk++;
      if (got_ops[i] !== exp_ops[i]) begin n_fail++; $display("FAIL write_op%0d: got %h required %h", i, got_ops[i], exp_ops[i]); end
    end
    foreach (exp_tx[i]) begin
      n_chk++;
      if (tx_got[i] !== exp_tx[i]) begin n_fail++; $display("FAIL write_tx_slot%0d: got %h required %h", i + 1, tx_got[i], exp_tx[i]); end
    end
    n_chk++;
    if (busy !== 1'b0 || err !== exp_err) begin n_fail++; $display("FAIL write_end: got busy=%b err=%b required 0 %b", busy, err, exp_err); end
  endtask

  task automatic test_read();
    ack_en = 1'b1;
    salt = 8'(($urandom & 32'hFF) | 32'h1);
    frame_q = '{8'h80, 8'h20, 8'h33, 8'h44, 8'h55};
    model();
    run_frame();
    n_chk++;
    if (got_ops.size() !== exp_ops.size()) begin n_fail++; $display("FAIL read_count: got %0d required %0d", got_ops.size(), exp_ops.size()); end
    foreach (exp_ops[i]) if (i < got_ops.size()) begin
      n_chk++;
      if (got_ops[i] !== exp_ops[i]) begin n_fail++; $display("FAIL read_op%0d: got %h required %h", i, got_ops[i], exp_ops[i]); end
    end
    foreach (exp_tx[i]) begin
      n_chk++;
      if (tx_got[i] !== exp_tx[i]) begin n_fail++; $display("FAIL read_tx_slot%0d: got %h required %h", i + 1, tx_got[i], exp_tx[i]); end
    end
    n_chk++;
    if (busy !== 1'b0 || output_axis_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL read_end: got busy=%b tvalid=%b required 0 0", busy, output_axis_tvalid);
    end
  endtask

  task automatic test_timeout();
    ack_en = 1'b0;
    frame_q = '{8'h80, 8'h30, 8'h00, 8'h00};
    model();
    run_frame();
    n_chk++;
    if (got_ops.size() !== exp_ops.size()) begin n_fail++; $display("FAIL tmo_count: got %0d required %0d", got_ops.size(), exp_ops.size()); end
    foreach (exp_ops[i]) if (i < got_ops.size()) begin
      n_chk++;
      if (got_ops[i] !== exp_ops[i]) begin n_fail++; $display("FAIL tmo_op%0d: got %h required %h", i, got_ops[i], exp_ops[i]); end
    end
    foreach (exp_tx[i]) begin
      n_chk++;
      if (tx_got[i] !== exp_tx[i]) begin n_fail++; $display("FAIL tmo_tx_slot%0d: got %h required %h", i + 1, tx_got[i], exp_tx[i]); end
    end
    n_chk++;
    if (err !== exp_err || busy !== 1'b0) begin n_fail++; $display("FAIL tmo_err: got err=%b busy=%b required %b 0", err, busy, exp_err); end
    ack_en = 1'b1;
  endtask

  task automatic test_abort();
    ack_en = 1'b1;
    frame_q = '{8'h80};
    model();
    run_frame();
    n_chk++;
    if (got_ops.size() !== 0 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL abort_cmd: got ops=%0d busy=%b err=%b required 0 0 0", got_ops.size(), busy, err);
    end
    frame_q = '{8'h00, 8'h05, 8'h11};
    model();
    run_frame();
    n_chk++;
    if (got_ops.size() !== exp_ops.size()) begin n_fail++; $display("FAIL abort_next_count: got %0d required %0d", got_ops.size(), exp_ops.size()); end
    foreach (exp_ops[i]) if (i < got_ops.size()) begin
      n_chk++;
      if (got_ops[i] !== exp_ops[i]) begin n_fail++; $display("FAIL abort_next_op%0d: got %h required %h", i, got_ops[i], exp_ops[i]); end
    end
    n_chk++;
    if (err !== exp_err) begin n_fail++; $display("FAIL abort_next_err: got %b required %b", err, exp_err); end
  endtask

  task automatic test_wrap();
    ack_en = 1'b1;
    frame_q = '{8'h00, 8'hFF, 8'h01, 8'h02};
    model();
    run_frame();
    n_chk++;
    if (got_ops.size() !== exp_ops.size()) begin n_fail++; $display("FAIL wrap_count: got %0d required %0d", got_ops.size(), exp_ops.size()); end
    foreach (exp_ops[i]) if (i < got_ops.size()) begin
      n_chk++;
      if (got_ops[i] !== exp_ops[i]) begin n_fail++; $display("FAIL wrap_op%0d: got %h required %h", i, got_ops[i], exp_ops[i]); end
    end
  endtask

  task automatic test_random();
    int n;
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 6);
      ack_en = ($urandom_range(0, 3) != 0);
      salt = 8'($urandom);
      frame_q.delete();
      for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom));
      model();
      run_frame();
      n_chk++;
      if (got_ops.size() !== exp_ops.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d required %0d", f, got_ops.size(), exp_ops.size()); end
      foreach (exp_ops[i]) if (i < got_ops.size()) begin
        n_chk++;
        if (got_ops[i] !== exp_ops[i]) begin n_fail++; $display("FAIL rand%0d_op%0d: got %h required %h", f, i, got_ops[i], exp_ops[i]); end
      end
      foreach (exp_tx[i]) begin
        n_chk++;
        if (tx_got[i] !== exp_tx[i]) begin n_fail++; $display("FAIL rand%0d_tx_slot%0d: got %h required %h", f, i + 1, tx_got[i], exp_tx[i]); end
      end
      n_chk++;
      if (err !== exp_err || busy !== 1'b0 || output_axis_tvalid !== 1'b0) begin
        n_fail++; $display("FAIL rand%0d_end: got err=%b busy=%b tvalid=%b required %b 0 0", f, err, busy, output_axis_tvalid, exp_err);
      end
    end
    ack_en = 1'b1;
  endtask

  task automatic test_reset_mid_access();
    logic [7:0] bytes[3];
    bit ok;
    bytes = '{8'h00, 8'h10, 8'hAA};
    ack_en = 1'b0;
    got_ops.delete();
    foreach (bytes[k]) begin
      input_axis_tdata  = bytes[k];
      input_axis_tvalid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
        if (input_axis_tready) begin
          @(posedge clk);
          ok = 1'b1;
        end
        @(negedge clk);
      end
      input_axis_tvalid = 1'b0;
    end
    repeat (5) @(negedge clk);
    n_chk++;
    if (busy !== 1'b1 || input_axis_tready !== 1'b0 || got_ops.size() !== 1) begin
      n_fail++; $display("FAIL rst_mid_pre: got busy=%b tready=%b ops=%0d required 1 0 1", busy, input_axis_tready, got_ops.size());
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({reg_wr_en, reg_rd_en, output_axis_tvalid, input_axis_tready, busy, err} !== 6'b0 || reg_addr !== 8'h00
        || reg_wr_data !== 8'h00) begin
      n_fail++; $display("FAIL rst_mid_outputs: got busy=%b tready=%b addr=%h wdata=%h, required all 0",
                         busy, input_axis_tready, reg_addr, reg_wr_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    n_chk++;
    if (got_ops.size() !== 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_after: got ops=%0d busy=%b required 1 0", got_ops.size(), busy);
    end
    ack_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_abort();
    test_wrap();
    test_random();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
